// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline run/step controller.
//   - Debug command encodings (2-bit i_cmd field)
//   - Controller state encoding
//   - Default pipeline depth of the five-stage MIPS core
package pipeline_ctrl_pkg;

    localparam logic [1:0] CMD_RUN   = 2'b01;
    localparam logic [1:0] CMD_STEP  = 2'b10;
    localparam logic [1:0] CMD_ABORT = 2'b11;

    localparam int DEFAULT_PIPE_DEPTH = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

endpackage

// File: rtl/load_down_counter.sv
// Loadable down counter with an "equals one" flag.
// Ports:
//   i_clk, i_reset_n : clock, async active-low reset (clears to 0)
//   i_load, i_load_val : load value (wins over decrement)
//   i_dec            : decrement by one; holds at zero
//   o_is_one         : counter currently equals 1
module load_down_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_is_one
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load)
            cnt_d = i_load_val;
        else if (i_dec && (cnt_q != '0))
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end

    assign o_is_one = (cnt_q == W'(1));

endmodule

// File: rtl/pipeline_step_ctrl.sv
// Run/step controller producing the single pipeline advance enable.
// Ports:
//   i_clk, i_reset_n        : clock, async active-low reset
//   i_cmd_valid/i_cmd/i_cmd_arg, o_cmd_ready : debug command handshake
//   i_halt_fetched          : HALT opcode present in IF
//   o_step                  : enable for all stage registers and the PC
//   o_running, o_halted     : status (RUN/STEP, HALTED)
//   o_done                  : one-cycle pulse on entry to IDLE or HALTED
//   o_cycle_count           : number of cycles with o_step high (wraps)
module pipeline_step_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int NB_CNT     = 32,
    parameter int NB_ARG     = 16,
    parameter int PIPE_DEPTH = DEFAULT_PIPE_DEPTH
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_cmd_valid,
    input  logic [1:0]        i_cmd,
    input  logic [NB_ARG-1:0] i_cmd_arg,
    output logic              o_cmd_ready,
    input  logic              i_halt_fetched,
    output logic              o_step,
    output logic              o_running,
    output logic              o_halted,
    output logic              o_done,
    output logic [NB_CNT-1:0] o_cycle_count
);

    localparam int DRN_W = $clog2(PIPE_DEPTH + 1);

    state_e            state_q, state_d;
    logic              done_q, done_d;
    logic [NB_CNT-1:0] cycle_cnt_q, cycle_cnt_d;

    logic              rem_load, rem_dec, rem_is_one;
    logic              drn_load, drn_dec, drn_is_one;
    logic [NB_ARG-1:0] rem_val;
    logic              cmd_acc;

    // Moore outputs straight from the state register so they only move
    // after a rising edge.
    assign o_step      = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_DRAIN);
    assign o_running   = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign o_halted    = (state_q == ST_HALTED);
    assign o_cmd_ready = (state_q == ST_IDLE) || o_running;
    assign o_done      = done_q;
    assign o_cycle_count = cycle_cnt_q;

    assign cmd_acc = i_cmd_valid && o_cmd_ready;
    assign rem_val = (i_cmd_arg == '0) ? NB_ARG'(1) : i_cmd_arg;

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        rem_load = 1'b0;
        rem_dec  = 1'b0;
        drn_load = 1'b0;
        drn_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // ABORT and the reserved code are silently dropped here
                if (cmd_acc && (i_cmd == CMD_RUN)) begin
                    state_d = ST_RUN;
                end else if (cmd_acc && (i_cmd == CMD_STEP)) begin
                    state_d  = ST_STEP;
                    rem_load = 1'b1;
                end
            end
            ST_RUN, ST_STEP: begin
                // HALT outranks ABORT and step expiry so older instructions
                // always retire.
                if (i_halt_fetched) begin
                    state_d  = ST_DRAIN;
                    drn_load = 1'b1;
                end else if (cmd_acc && (i_cmd == CMD_ABORT)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (state_q == ST_STEP) begin
                    if (rem_is_one) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rem_dec = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                drn_dec = 1'b1;
                if (drn_is_one) begin
                    state_d = ST_HALTED;
                    done_d  = 1'b1;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cycle_cnt_d = cycle_cnt_q + NB_CNT'(o_step);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            done_q      <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    load_down_counter #(.W(NB_ARG)) u_remaining (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_load     (rem_load),
        .i_load_val (rem_val),
        .i_dec      (rem_dec),
        .o_is_one   (rem_is_one)
    );

    load_down_counter #(.W(DRN_W)) u_drain (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_load     (drn_load),
        .i_load_val (DRN_W'(PIPE_DEPTH - 1)),
        .i_dec      (drn_dec),
        .o_is_one   (drn_is_one)
    );

endmodule

// File: tb/tb_pipeline_step_ctrl.sv
module tb_pipeline_step_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [1:0]  cmd = 2'b00;
    logic [15:0] arg = 16'd0;
    logic        halt = 1'b0;
    logic        ready, step, running, halted, done;
    logic [31:0] cnt;

    // narrow-counter instance for the wrap check
    logic        v2 = 1'b0;
    logic [1:0]  c2 = 2'b00;
    logic [15:0] a2 = 16'd0;
    logic        h2 = 1'b0;
    logic        ready2, step2, running2, halted2, done2;
    logic [3:0]  cnt2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipeline_step_ctrl dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_cmd_valid(valid), .i_cmd(cmd),
        .i_cmd_arg(arg), .o_cmd_ready(ready), .i_halt_fetched(halt),
        .o_step(step), .o_running(running), .o_halted(halted),
        .o_done(done), .o_cycle_count(cnt)
    );

    pipeline_step_ctrl #(.NB_CNT(4)) dut2 (
        .i_clk(clk), .i_reset_n(rst_n), .i_cmd_valid(v2), .i_cmd(c2),
        .i_cmd_arg(a2), .o_cmd_ready(ready2), .i_halt_fetched(h2),
        .o_step(step2), .o_running(running2), .o_halted(halted2),
        .o_done(done2), .o_cycle_count(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one rising edge, then park on the falling edge for checks/drive
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] c, input logic [15:0] a);
        valid = 1'b1; cmd = c; arg = a;
        tick();
        valid = 1'b0; cmd = 2'b00; arg = 16'd0;
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_step", step, 0);
        chk("rst_running", running, 0);
        chk("rst_halted", halted, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_ready", ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // STEP 3
        send(2'b10, 16'd3);
        chk("s3_c1", step, 1);
        chk("s3_run", running, 1);
        tick(); chk("s3_c2", step, 1);
        tick(); chk("s3_c3", step, 1);
        chk("s3_nodone", done, 0);
        tick();
        chk("s3_end_step", step, 0);
        chk("s3_done", done, 1);
        chk("s3_cnt", cnt, 3);
        chk("s3_idle", running, 0);
        tick(); chk("s3_done_clr", done, 0);

        // STEP 0 behaves as STEP 1
        send(2'b10, 16'd0);
        chk("s0_c1", step, 1);
        tick();
        chk("s0_end", step, 0);
        chk("s0_done", done, 1);
        chk("s0_cnt", cnt, 4);
        tick();

        // RUN then ABORT 10 cycles later
        send(2'b01, 16'd0);
        chk("run_step", step, 1);
        repeat (9) tick();
        chk("run_still", step, 1);
        send(2'b11, 16'd0);
        chk("abort_step", step, 0);
        chk("abort_done", done, 1);
        chk("abort_cnt", cnt, 14);
        send(2'b11, 16'd0);
        chk("idle_abort_done", done, 0);
        chk("idle_abort_step", step, 0);
        chk("idle_abort_cnt", cnt, 14);

        // RUN, HALT on cycle 7 with simultaneous ABORT
        send(2'b01, 16'd0);
        repeat (6) tick();
        halt = 1'b1;
        send(2'b11, 16'd0);
        halt = 1'b0;
        chk("drn_step", step, 1);
        chk("drn_ready", ready, 0);
        chk("drn_running", running, 0);
        chk("drn_done", done, 0);
        chk("drn_cnt", cnt, 21);
        repeat (3) tick();
        chk("drn_step4", step, 1);
        chk("drn_halted_early", halted, 0);
        tick();
        chk("hlt_halted", halted, 1);
        chk("hlt_done", done, 1);
        chk("hlt_step", step, 0);
        chk("hlt_cnt", cnt, 25);
        chk("hlt_ready", ready, 0);
        send(2'b01, 16'd0);
        tick();
        chk("hlt_run_ign", step, 0);
        chk("hlt_stay", halted, 1);
        chk("hlt_done_clr", done, 0);
        chk("hlt_cnt_hold", cnt, 25);

        // reset out of HALTED, then STEP 5 interrupted by reset
        rst_n = 1'b0;
        #2;
        chk("rst2_halted", halted, 0);
        chk("rst2_cnt", cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send(2'b10, 16'd5);
        tick(); tick();
        chk("s5_cnt2", cnt, 2);
        chk("s5_step", step, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("s5_rst_step", step, 0);
        chk("s5_rst_running", running, 0);
        chk("s5_rst_cnt", cnt, 0);
        chk("s5_rst_done", done, 0);
        chk("s5_rst_ready", ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send(2'b10, 16'd1);
        chk("s1_step", step, 1);
        tick();
        chk("s1_end", step, 0);
        chk("s1_done", done, 1);
        chk("s1_cnt", cnt, 1);

        // 4-bit counter wrap: 18 RUN cycles
        v2 = 1'b1; c2 = 2'b01;
        tick();
        v2 = 1'b0; c2 = 2'b00;
        repeat (17) tick();
        chk("w_cnt17", {28'd0, cnt2}, 1);
        v2 = 1'b1; c2 = 2'b11;
        tick();
        v2 = 1'b0; c2 = 2'b00;
        chk("w_cnt18", {28'd0, cnt2}, 2);
        chk("w_step", step2, 0);
        chk("w_done", done2, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
